// File: rtl/hilo_div_unit.sv
// HI/LO register pair with two direct write slots and a sequential restoring divider.
// Divider results (quotient -> LO, remainder -> HI) yield per register to same-edge direct writes.
module hilo_div_unit #(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_hi_1,
    input  logic             we_lo_1,
    input  logic [WIDTH-1:0] wd_hi_1,
    input  logic [WIDTH-1:0] wd_lo_1,
    input  logic             we_hi_2,
    input  logic             we_lo_2,
    input  logic [WIDTH-1:0] wd_hi_2,
    input  logic [WIDTH-1:0] wd_lo_2,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    input  logic             div_flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    div_state_t state;
    div_state_t state_next;

    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] dividend_raw;
    logic             neg_quo;
    logic             neg_rem;
    logic             div_zero;

    logic             start_ok;
    logic             last_bit;
    logic             result_wr;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign start_ok = (state == IDLE) && div_start && !div_flush;
    assign last_bit = (count == LAST_COUNT);

    // ---------------- divider FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- divider FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_ok) state_next = RUN;
            RUN: begin
                if (div_flush)     state_next = IDLE;
                else if (last_bit) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- divider FSM: outputs ----------------
    always_comb begin
        busy      = 1'b0;
        result_wr = 1'b0;
        case (state)
            RUN: busy = 1'b1;
            FIX: begin
                busy      = 1'b1;
                result_wr = !div_flush;
            end
            default: begin
                busy      = 1'b0;
                result_wr = 1'b0;
            end
        endcase
    end

    // Signed operands are reduced to magnitudes; signs are reapplied in FIX.
    assign a_neg = div_signed && div_a[WIDTH-1];
    assign b_neg = div_signed && div_b[WIDTH-1];
    assign a_mag = a_neg ? (~div_a + ONE) : div_a;
    assign b_mag = b_neg ? (~div_b + ONE) : div_b;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {part_rem, quo[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, divisor};
    assign trial_ok  = !trial[WIDTH];

    // Divide by zero bypasses sign correction so HI returns the raw dividend.
    assign quo_fix = div_zero ? {WIDTH{1'b1}} : (neg_quo ? (~quo + ONE) : quo);
    assign rem_fix = div_zero ? dividend_raw  : (neg_rem ? (~part_rem + ONE) : part_rem);

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            part_rem     <= '0;
            quo          <= '0;
            divisor      <= '0;
            dividend_raw <= '0;
            neg_quo      <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= result_wr;
            if (start_ok) begin
                count        <= '0;
                part_rem     <= '0;
                quo          <= a_mag;
                divisor      <= b_mag;
                dividend_raw <= div_a;
                neg_quo      <= a_neg ^ b_neg;
                neg_rem      <= a_neg;
                div_zero     <= (div_b == '0);
            end else if (state == RUN) begin
                count    <= count + CW'(1);
                quo      <= {quo[WIDTH-2:0], trial_ok};
                part_rem <= trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            end
        end
    end

    // Per-register priority: slot 2, then slot 1, then divider result.
    always_comb begin
        hi_next = hi_reg;
        if (we_hi_2)        hi_next = wd_hi_2;
        else if (we_hi_1)   hi_next = wd_hi_1;
        else if (result_wr) hi_next = rem_fix;
    end

    always_comb begin
        lo_next = lo_reg;
        if (we_lo_2)        lo_next = wd_lo_2;
        else if (we_lo_1)   lo_next = wd_lo_1;
        else if (result_wr) lo_next = quo_fix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
        end
    end

    // Forwarding covers direct writes only; divider results show after the edge.
    always_comb begin
        hi_data = hi_reg;
        lo_data = lo_reg;
        if (BYPASS) begin
            if (we_hi_2)      hi_data = wd_hi_2;
            else if (we_hi_1) hi_data = wd_hi_1;
            if (we_lo_2)      lo_data = wd_lo_2;
            else if (we_lo_1) lo_data = wd_lo_1;
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: divide results go through an expected queue
// checked on each done pulse; register-file behaviour is checked in place.
module tb_hilo_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         we_hi_1, we_lo_1, we_hi_2, we_lo_2;
    logic [W-1:0] wd_hi_1, wd_lo_1, wd_hi_2, wd_lo_2;
    logic         div_start, div_signed, div_flush;
    logic [W-1:0] div_a, div_b;
    logic         busy, done;
    logic [W-1:0] hi_data, lo_data;
    logic         bp_busy, bp_done;
    logic [W-1:0] bp_hi, bp_lo;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;
    int vec_count  = 0;
    int miss_count = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    hilo_div_unit #(.WIDTH(W), .BYPASS(1'b0)) dut (
        .clk(clk), .reset(reset),
        .we_hi_1(we_hi_1), .we_lo_1(we_lo_1), .wd_hi_1(wd_hi_1), .wd_lo_1(wd_lo_1),
        .we_hi_2(we_hi_2), .we_lo_2(we_lo_2), .wd_hi_2(wd_hi_2), .wd_lo_2(wd_lo_2),
        .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
        .div_flush(div_flush), .busy(busy), .done(done),
        .hi_data(hi_data), .lo_data(lo_data)
    );

    hilo_div_unit #(.WIDTH(W), .BYPASS(1'b1)) dut_bp (
        .clk(clk), .reset(reset),
        .we_hi_1(we_hi_1), .we_lo_1(we_lo_1), .wd_hi_1(wd_hi_1), .wd_lo_1(wd_lo_1),
        .we_hi_2(we_hi_2), .we_lo_2(we_lo_2), .wd_hi_2(wd_hi_2), .wd_lo_2(wd_lo_2),
        .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
        .div_flush(div_flush), .busy(bp_busy), .done(bp_done),
        .hi_data(bp_hi), .lo_data(bp_lo)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                vec_count++;
                miss_count++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_exp = exp_q.pop_front();
                check("div_hi", hi_data, mon_exp[2*W-1:W]);
                check("div_lo", lo_data, mon_exp[W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        we_hi_1 = 1'b0; we_lo_1 = 1'b0; we_hi_2 = 1'b0; we_lo_2 = 1'b0;
        wd_hi_1 = '0; wd_lo_1 = '0; wd_hi_2 = '0; wd_lo_2 = '0;
        div_start = 1'b0; div_signed = 1'b0; div_a = '0; div_b = '0; div_flush = 1'b0;
    endtask

    // Issues one divide and counts busy cycles; optional stray start while busy
    // and optional slot-2 LO write on the completion edge.
    task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                           input bit poke, input bit lo2_at_end);
        int n;
        exp_q.push_back({exp_hi, exp_lo});
        div_start = 1'b1; div_signed = sgn; div_a = a; div_b = b;
        tick();
        div_start = 1'b0;
        div_a = ~a;
        div_b = b ^ 32'h5;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (poke && n == 5) begin
                div_start = 1'b1; div_signed = ~sgn; div_a = 32'd1000; div_b = 32'd3;
            end
            if (poke && n == 6) div_start = 1'b0;
            if (lo2_at_end && n == W + 1) begin
                we_lo_2 = 1'b1; wd_lo_2 = 32'h0000_AAAA;
            end
        end
        we_lo_2 = 1'b0;
        div_start = 1'b0;
        check("busy_cycles", W'(n), W'(W + 1));
        check("done_pulse", W'(done), W'(1));
        tick();
        check("done_single", W'(done), W'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_hi", hi_data, 32'h0);
        check("reset_lo", lo_data, 32'h0);
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        tick();

        // Same-edge slot priority; bypass instance forwards combinationally.
        we_hi_1 = 1'b1; wd_hi_1 = 32'h1111;
        we_hi_2 = 1'b1; wd_hi_2 = 32'h2222;
        we_lo_1 = 1'b1; wd_lo_1 = 32'h3333;
        #2;
        check("bypass_hi", bp_hi, 32'h2222);
        check("bypass_lo", bp_lo, 32'h3333);
        check("nobypass_hi", hi_data, 32'h0);
        tick();
        clear_inputs();
        check("prio_hi", hi_data, 32'h2222);
        check("prio_lo", lo_data, 32'h3333);
        check("bypass_reg_hi", bp_hi, 32'h2222);

        run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_div(1'b0, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_div(1'b0, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0000_AAAA, 1'b0, 1'b1);

        // Flush on the 10th busy cycle.
        div_start = 1'b1; div_signed = 1'b0; div_a = 32'd100; div_b = 32'd7;
        tick();
        div_start = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("flush_busy_before", W'(n), W'(10));
        div_flush = 1'b1;
        tick();
        div_flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", W'(busy), W'(0));
        check("flush_hi", hi_data, 32'h1234_5678);
        check("flush_lo", lo_data, 32'h0000_AAAA);
        check("flush_done", W'(done), W'(0));
        for (int i = 0; i < 40; i++) @(negedge clk);
        check("flush_hi_late", hi_data, 32'h1234_5678);
        check("flush_lo_late", lo_data, 32'h0000_AAAA);
        tick();
        run_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b0);

        // Reset for two cycles in the middle of a divide.
        we_hi_1 = 1'b1; wd_hi_1 = 32'h55; we_lo_1 = 1'b1; wd_lo_1 = 32'h66;
        tick();
        clear_inputs();
        div_start = 1'b1; div_a = 32'd100; div_b = 32'd7;
        tick();
        div_start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midreset_hi", hi_data, 32'h0);
        check("midreset_lo", lo_data, 32'h0);
        check("midreset_busy", W'(busy), W'(0));
        check("midreset_done", W'(done), W'(0));
        tick();
        run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

        repeat (3) tick();
        check("pending_results", W'(exp_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
